cond_flag_reg: RTL and testbench

COND_FLAG_REG -- requirements
Module: cond_flag_reg

---
 rtl/cond_flag_reg.sv | 96 +++++++++
 tb/tb_cond_flag_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_reg.sv
// Condition flag register {N,Z,C,V} with a LIFO save stack and a registered
// ARM-style condition evaluator.
module cond_flag_reg #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] flag_in,
    input  logic       flag_we,
    input  logic       push,
    input  logic       pop,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    input  logic       err_clr,
    output logic [3:0] flags_out,
    output logic       taken,
    output logic       taken_valid,
    output logic [4:0] depth,
    output logic       full,
    output logic       empty,
    output logic       err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [3:0]    stack [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          do_push;
    logic          do_pop;
    logic          err_ev;
    logic          cond_res;
    logic          n, z, c, v;

    assign full    = (depth == 5'(DEPTH));
    assign empty   = (depth == 5'd0);
    assign wr_idx  = depth[AW-1:0];
    assign rd_idx  = wr_idx - AW'(1);

    // Push and pop together cancel out and are never treated as an error.
    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;
    assign err_ev  = (push & ~pop & full) | (pop & ~push & empty);

    assign {n, z, c, v} = flags_out;

    always_comb begin
        cond_res = 1'b0;
        case (cond_code)
            4'h0: cond_res = z;
            4'h1: cond_res = ~z;
            4'h2: cond_res = c;
            4'h3: cond_res = ~c;
            4'h4: cond_res = n;
            4'h5: cond_res = ~n;
            4'h6: cond_res = v;
            4'h7: cond_res = ~v;
            4'h8: cond_res = c & ~z;
            4'h9: cond_res = ~c | z;
            4'hA: cond_res = (n == v);
            4'hB: cond_res = (n != v);
            4'hC: cond_res = ~z & (n == v);
            4'hD: cond_res = z | (n != v);
            4'hE: cond_res = 1'b1;
            default: cond_res = 1'b0;
        endcase
    end

    // Stack storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) stack[wr_idx] <= flags_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_out   <= '0;
            depth       <= '0;
            err         <= 1'b0;
            taken       <= 1'b0;
            taken_valid <= 1'b0;
        end else begin
            if (do_pop)       flags_out <= stack[rd_idx];
            else if (flag_we) flags_out <= flag_in;

            if (do_push)      depth <= depth + 5'd1;
            else if (do_pop)  depth <= depth - 5'd1;

            if (err_ev)       err <= 1'b1;
            else if (err_clr) err <= 1'b0;

            taken_valid <= cond_valid;
            if (cond_valid) taken <= cond_res;
        end
    end

endmodule

// File: tb/tb_cond_flag_reg.sv
// Directed self-checking bench for cond_flag_reg with DEPTH=4.
module tb_cond_flag_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] flag_in;
    logic       flag_we;
    logic       push;
    logic       pop;
    logic       cond_valid;
    logic [3:0] cond_code;
    logic       err_clr;
    logic [3:0] flags_out;
    logic       taken;
    logic       taken_valid;
    logic [4:0] depth;
    logic       full;
    logic       empty;
    logic       err;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    cond_flag_reg #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flag_in(flag_in), .flag_we(flag_we),
        .push(push), .pop(pop), .cond_valid(cond_valid), .cond_code(cond_code),
        .err_clr(err_clr), .flags_out(flags_out), .taken(taken),
        .taken_valid(taken_valid), .depth(depth), .full(full), .empty(empty),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flag_we = 1'b0; push = 1'b0; pop = 1'b0; cond_valid = 1'b0; err_clr = 1'b0;
    endtask

    task automatic load(input logic [3:0] f);
        flag_in = f; flag_we = 1'b1;
        cyc();
        flag_we = 1'b0;
    endtask

    // Runs all 16 codes back to back; mask bit i is the expected result of code i.
    task automatic sweep(input string tag, input logic [15:0] mask);
        cond_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cond_code = 4'(i);
            cyc();
            chk($sformatf("%s_c%0h_taken", tag, i), 32'(taken), 32'(mask[i]));
            chk($sformatf("%s_c%0h_tv", tag, i), 32'(taken_valid), 32'd1);
        end
        cond_valid = 1'b0;
        cyc();
        chk({tag, "_tv_drop"}, 32'(taken_valid), 32'd0);
        chk({tag, "_taken_hold"}, 32'(taken), 32'(mask[15]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] vals [5];

    initial begin
        vals[0] = 4'h1; vals[1] = 4'h2; vals[2] = 4'h4; vals[3] = 4'h8; vals[4] = 4'hF;
        rst = 1'b1; flag_in = '0; cond_code = '0;
        idle();
        #3;
        chk("rst_flags", 32'(flags_out), 32'h0);
        chk("rst_depth", 32'(depth), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_tv", 32'(taken_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // EQ / NE on Z set
        load(4'b0100);
        chk("ld_flags", 32'(flags_out), 32'h4);
        cond_valid = 1'b1; cond_code = 4'h0;
        cyc();
        chk("eq_taken", 32'(taken), 32'h1);
        chk("eq_tv", 32'(taken_valid), 32'h1);
        cond_code = 4'h1;
        cyc();
        chk("ne_taken", 32'(taken), 32'h0);
        chk("ne_tv", 32'(taken_valid), 32'h1);
        // Same-cycle flag_we must not be seen by the query
        cond_code = 4'h0; flag_we = 1'b1; flag_in = 4'b0000;
        cyc();
        chk("nobyp_taken", 32'(taken), 32'h1);
        chk("nobyp_flags", 32'(flags_out), 32'h0);
        idle();
        cyc();
        chk("idle_tv", 32'(taken_valid), 32'h0);

        load(4'b1000);
        sweep("f1000", 16'h6A9A);
        load(4'b0010);
        sweep("f0010", 16'h55A6);
        load(4'b0101);
        sweep("f0101", 16'h6A69);

        // Fill to overflow, then drain to underflow
        for (int k = 0; k < 5; k++) begin
            load(vals[k]);
            push = 1'b1;
            cyc();
            push = 1'b0;
            chk($sformatf("push%0d_depth", k), 32'(depth), (k < 4) ? 32'(k + 1) : 32'd4);
            chk($sformatf("push%0d_err", k), 32'(err), (k < 4) ? 32'd0 : 32'd1);
        end
        chk("ovf_full", 32'(full), 32'h1);
        chk("ovf_flags", 32'(flags_out), 32'hF);
        for (int k = 3; k >= 0; k--) begin
            pop = 1'b1;
            cyc();
            pop = 1'b0;
            chk($sformatf("pop%0d_flags", k), 32'(flags_out), 32'(vals[k]));
            chk($sformatf("pop%0d_depth", k), 32'(depth), 32'(k));
        end
        chk("drain_empty", 32'(empty), 32'h1);
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        chk("unf_depth", 32'(depth), 32'h0);
        chk("unf_flags", 32'(flags_out), 32'h1);
        chk("unf_err", 32'(err), 32'h1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("errclr", 32'(err), 32'h0);
        pop = 1'b1; err_clr = 1'b1;
        cyc();
        idle();
        chk("err_vs_clr", 32'(err), 32'h1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("errclr2", 32'(err), 32'h0);

        // Push with flag_we, pop overriding flag_we
        load(4'b1100);
        push = 1'b1; flag_we = 1'b1; flag_in = 4'b0011;
        cyc();
        idle();
        chk("pushwe_flags", 32'(flags_out), 32'h3);
        chk("pushwe_depth", 32'(depth), 32'h1);
        pop = 1'b1; flag_we = 1'b1; flag_in = 4'b0001;
        cyc();
        idle();
        chk("popwe_flags", 32'(flags_out), 32'hC);
        chk("popwe_depth", 32'(depth), 32'h0);

        // Simultaneous push and pop
        push = 1'b1;
        cyc(); cyc();
        push = 1'b1; pop = 1'b1; flag_we = 1'b1; flag_in = 4'b0110;
        cyc();
        idle();
        chk("pp_depth", 32'(depth), 32'h2);
        chk("pp_err", 32'(err), 32'h0);
        chk("pp_flags", 32'(flags_out), 32'h6);
        push = 1'b1;
        cyc();
        push = 1'b0;
        chk("pre_rst_depth", 32'(depth), 32'h3);

        // Asynchronous reset between edges with a query pending
        cond_valid = 1'b1; cond_code = 4'hE;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_flags", 32'(flags_out), 32'h0);
        chk("arst_depth", 32'(depth), 32'h0);
        chk("arst_empty", 32'(empty), 32'h1);
        chk("arst_full", 32'(full), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        chk("arst_taken", 32'(taken), 32'h0);
        chk("arst_tv", 32'(taken_valid), 32'h0);
        cyc();
        chk("arst_hold_tv", 32'(taken_valid), 32'h0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        cyc();
        chk("post_rst_tv", 32'(taken_valid), 32'h0);
        chk("post_rst_depth", 32'(depth), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
